// File: rtl/pong_motion_ctrl.sv
// Per-frame Pong motion controller: paddle/ball positions, ball velocity and the
// serve / play / miss sequencing, all advanced once per frame_tick.
module pong_motion_ctrl #(
  parameter int BAR_V       = 4,
  parameter int BALL_V      = 2,
  parameter int BAR_H       = 72,
  parameter int BALL_SIZE   = 8,
  parameter int WALL_R      = 35,
  parameter int TOP_B       = 5,
  parameter int BOT_T       = 475,
  parameter int BAR_XL      = 600,
  parameter int BAR_XR      = 603,
  parameter int MISS_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       btn_up,
  input  logic       btn_down,
  input  logic       start,
  output logic [9:0] bar_y_t,
  output logic [9:0] ball_x_l,
  output logic [9:0] ball_y_t,
  output logic       playing,
  output logic       hit,
  output logic       miss
);

  localparam logic [9:0] BAR_Y_RST  = 10'd204;
  localparam logic [9:0] BALL_X_RST = 10'd580;
  localparam logic [9:0] BALL_Y_RST = 10'd238;
  localparam logic [9:0] STEP_BAR   = 10'(BAR_V);
  localparam logic [9:0] STEP_BALL  = 10'(BALL_V);
  localparam logic [9:0] BAR_MIN    = 10'(TOP_B + 1);
  localparam logic [9:0] BAR_MAX    = 10'(BOT_T - BAR_H);
  localparam logic [9:0] TOP_LIM    = 10'(TOP_B + 1);
  localparam logic [9:0] BOT_LIM    = 10'(BOT_T - 1);
  localparam logic [9:0] WALL_LIM   = 10'(WALL_R + 1);
  localparam logic [9:0] PAD_XL     = 10'(BAR_XL);
  localparam logic [9:0] PAD_XR     = 10'(BAR_XR);
  localparam logic [9:0] BALL_EXT   = 10'(BALL_SIZE - 1);
  localparam logic [9:0] BAR_EXT    = 10'(BAR_H - 1);
  localparam logic [9:0] MISS_LAST  = 10'(MISS_FRAMES - 1);

  typedef enum logic [1:0] {IDLE, PLAY, MISS_WAIT} state_t;

  state_t     state_q, state_d;
  logic [9:0] bar_q, bar_d;
  logic [9:0] bx_q, bx_d;
  logic [9:0] by_q, by_d;
  logic       dx_pos_q, dx_pos_d;
  logic       dy_pos_q, dy_pos_d;
  logic [9:0] cnt_q, cnt_d;
  logic       hit_q, hit_d;
  logic       miss_q, miss_d;
  logic       playing_q;

  logic [9:0] ball_r, ball_b, bar_b;
  logic       dx_new, dy_new, pad_hit;

  // Saturating paddle step: clamps against the top and bottom walls without wrap.
  function automatic logic [9:0] bar_step(input logic [9:0] y, input logic up, input logic dn);
    logic [9:0] r;
    r = y;
    if (up && !dn) r = (y >= BAR_MIN + STEP_BAR) ? y - STEP_BAR : BAR_MIN;
    else if (dn && !up) r = (y + STEP_BAR <= BAR_MAX) ? y + STEP_BAR : BAR_MAX;
    return r;
  endfunction

  function automatic logic [9:0] ball_step(input logic [9:0] p, input logic pos);
    return pos ? p + STEP_BALL : p - STEP_BALL;
  endfunction

  assign ball_r  = bx_q + BALL_EXT;
  assign ball_b  = by_q + BALL_EXT;
  assign bar_b   = bar_q + BAR_EXT;
  assign pad_hit = dx_pos_q && (ball_r >= PAD_XL) && (ball_r <= PAD_XR) &&
                   (ball_b >= bar_q) && (by_q <= bar_b);

  always_comb begin
    state_d  = state_q;
    bar_d    = bar_q;
    bx_d     = bx_q;
    by_d     = by_q;
    dx_pos_d = dx_pos_q;
    dy_pos_d = dy_pos_q;
    cnt_d    = cnt_q;
    hit_d    = 1'b0;
    miss_d   = 1'b0;
    dx_new   = dx_pos_q;
    dy_new   = dy_pos_q;

    if (frame_tick && state_q != MISS_WAIT) bar_d = bar_step(bar_q, btn_up, btn_down);

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d  = PLAY;
          dx_pos_d = 1'b0;
          dy_pos_d = 1'b1;
        end
      end
      PLAY: begin
        if (frame_tick) begin
          if (bx_q > PAD_XR) begin
            miss_d  = 1'b1;
            state_d = MISS_WAIT;
            cnt_d   = '0;
          end else begin
            // x and y reflect independently, both judged on pre-update positions
            if (by_q <= TOP_LIM)      dy_new = 1'b1;
            else if (ball_b >= BOT_LIM) dy_new = 1'b0;
            if (bx_q <= WALL_LIM) dx_new = 1'b1;
            else if (pad_hit) begin
              dx_new = 1'b0;
              hit_d  = 1'b1;
            end
            dx_pos_d = dx_new;
            dy_pos_d = dy_new;
            bx_d     = ball_step(bx_q, dx_new);
            by_d     = ball_step(by_q, dy_new);
          end
        end
      end
      MISS_WAIT: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            state_d  = IDLE;
            cnt_d    = '0;
            bx_d     = BALL_X_RST;
            by_d     = BALL_Y_RST;
            dx_pos_d = 1'b0;
            dy_pos_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 10'd1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      bar_q     <= BAR_Y_RST;
      bx_q      <= BALL_X_RST;
      by_q      <= BALL_Y_RST;
      dx_pos_q  <= 1'b0;
      dy_pos_q  <= 1'b1;
      cnt_q     <= '0;
      hit_q     <= 1'b0;
      miss_q    <= 1'b0;
      playing_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      bar_q     <= bar_d;
      bx_q      <= bx_d;
      by_q      <= by_d;
      dx_pos_q  <= dx_pos_d;
      dy_pos_q  <= dy_pos_d;
      cnt_q     <= cnt_d;
      hit_q     <= hit_d;
      miss_q    <= miss_d;
      playing_q <= (state_d == PLAY);
    end
  end

  assign bar_y_t  = bar_q;
  assign ball_x_l = bx_q;
  assign ball_y_t = by_q;
  assign playing  = playing_q;
  assign hit      = hit_q;
  assign miss     = miss_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Bench for pong_motion_ctrl: directed scenarios plus random stimulus, every cycle
// compared against a game-rule reference model held in plain integers.
module tb_pong_motion_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, frame_tick, btn_up, btn_down, start;
  logic [9:0] bar_y_t, ball_x_l, ball_y_t;
  logic       playing, hit, miss;

  pong_motion_ctrl dut (
    .clk(clk), .reset(reset), .frame_tick(frame_tick), .btn_up(btn_up),
    .btn_down(btn_down), .start(start), .bar_y_t(bar_y_t), .ball_x_l(ball_x_l),
    .ball_y_t(ball_y_t), .playing(playing), .hit(hit), .miss(miss)
  );

  int checks = 0;
  int failures = 0;

  // Reference model: 0 = idle, 1 = play, 2 = waiting after a miss
  int m_state, m_bar, m_bx, m_by, m_dx, m_dy, m_cnt, m_hit, m_miss, m_play;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_clk();
    int nb;
    if (reset) begin
      m_state = 0; m_bar = 204; m_bx = 580; m_by = 238; m_dx = -2; m_dy = 2;
      m_cnt = 0; m_hit = 0; m_miss = 0; m_play = 0;
      return;
    end
    m_hit = 0; m_miss = 0; nb = m_bar;
    if (frame_tick && m_state != 2) begin
      if (btn_up && !btn_down) nb = (m_bar - 4 < 6) ? 6 : m_bar - 4;
      else if (btn_down && !btn_up) nb = (m_bar + 4 > 403) ? 403 : m_bar + 4;
    end
    if (m_state == 0) begin
      if (start) begin m_state = 1; m_dx = -2; m_dy = 2; end
    end else if (m_state == 1) begin
      if (frame_tick) begin
        if (m_bx > 603) begin
          m_miss = 1; m_state = 2; m_cnt = 0;
        end else begin
          if (m_by <= 6) m_dy = 2;
          else if (m_by + 7 >= 474) m_dy = -2;
          if (m_bx <= 36) m_dx = 2;
          else if (m_dx > 0 && m_bx + 7 >= 600 && m_bx + 7 <= 603 &&
                   m_by + 7 >= m_bar && m_by <= m_bar + 71) begin
            m_dx = -2; m_hit = 1;
          end
          m_bx += m_dx; m_by += m_dy;
        end
      end
    end else begin
      if (frame_tick) begin
        m_cnt++;
        if (m_cnt == 60) begin
          m_state = 0; m_cnt = 0; m_bx = 580; m_by = 238; m_dx = -2; m_dy = 2;
        end
      end
    end
    m_bar = nb;
    m_play = (m_state == 1) ? 1 : 0;
  endtask

  task automatic check_all();
    chk("bar_y_t", int'(bar_y_t), m_bar);
    chk("ball_x_l", int'(ball_x_l), m_bx);
    chk("ball_y_t", int'(ball_y_t), m_by);
    chk("playing", int'(playing), m_play);
    chk("hit", int'(hit), m_hit);
    chk("miss", int'(miss), m_miss);
  endtask

  task automatic step(input logic r, input logic ft, input logic up, input logic dn, input logic st);
    reset = r; frame_tick = ft; btn_up = up; btn_down = dn; start = st;
    @(posedge clk);
    model_clk();
    #1;
    check_all();
  endtask

  task automatic frame(input logic up, input logic dn);
    step(1'b0, 1'b1, up, dn, 1'b0);
    step(1'b0, 1'b0, up, dn, 1'b0);
    step(1'b0, 1'b0, up, dn, 1'b0);
  endtask

  initial begin
    int saved_x, saved_y;
    bit seen;
    logic up, dn;
    reset = 1'b1; frame_tick = 1'b0; btn_up = 1'b0; btn_down = 1'b0; start = 1'b0;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_bar", int'(bar_y_t), 204);
    chk("rst_bx", int'(ball_x_l), 580);
    chk("rst_by", int'(ball_y_t), 238);
    chk("rst_play", int'(playing), 0);

    frame(1'b1, 1'b0);
    chk("up_once", int'(bar_y_t), 200);
    chk("idle_bx", int'(ball_x_l), 580);
    repeat (60) frame(1'b1, 1'b0);
    chk("clamp_top", int'(bar_y_t), 6);
    repeat (120) frame(1'b0, 1'b1);
    chk("clamp_bot", int'(bar_y_t), 403);
    repeat (5) frame(1'b1, 1'b1);
    chk("both_hold", int'(bar_y_t), 403);

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    frame(1'b0, 1'b0);
    chk("serve_play", int'(playing), 1);
    chk("serve_bx", int'(ball_x_l), 578);
    chk("serve_by", int'(ball_y_t), 240);
    repeat (114) frame(1'b0, 1'b0);
    chk("pre_bottom", int'(ball_y_t), 468);
    frame(1'b0, 1'b0);
    chk("bottom_bounce", int'(ball_y_t), 466);
    repeat (272 - 116) frame(1'b0, 1'b0);
    chk("near_wall", int'(ball_x_l), 36);
    frame(1'b0, 1'b0);
    chk("wall_bounce", int'(ball_x_l), 38);

    // Paddle tracks the ball until it is returned
    seen = 0;
    for (int i = 0; i < 1500 && !seen; i++) begin
      up = (m_bar + 36 > m_by + 6);
      dn = (m_bar + 36 < m_by + 2);
      step(1'b0, (i % 3) == 0, up, dn, 1'b0);
      if (m_hit == 1) seen = 1;
    end
    if (!seen) chk("hit_timeout", 0, 1);
    else begin
      chk("hit_pulse", int'(hit), 1);
      saved_x = int'(ball_x_l);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("hit_clear", int'(hit), 0);
      frame(1'b0, 1'b0);
      chk("after_hit_x", int'(ball_x_l), saved_x - 2);
    end

    // Paddle avoids the ball until it gets past
    seen = 0;
    for (int i = 0; i < 9000 && !seen; i++) begin
      up = (m_by >= 240);
      step(1'b0, (i % 3) == 0, up, !up, 1'b0);
      if (m_miss == 1) seen = 1;
    end
    if (!seen) chk("miss_timeout", 0, 1);
    else begin
      chk("miss_pulse", int'(miss), 1);
      chk("miss_play", int'(playing), 0);
      saved_x = int'(ball_x_l);
      saved_y = int'(ball_y_t);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      chk("miss_clear", int'(miss), 0);
      repeat (59) frame(1'b1, 1'b0);
      chk("frozen_x", int'(ball_x_l), saved_x);
      chk("frozen_y", int'(ball_y_t), saved_y);
      frame(1'b0, 1'b0);
      chk("reserve_x", int'(ball_x_l), 580);
      chk("reserve_y", int'(ball_y_t), 238);
    end

    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    repeat (10) frame(1'b0, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    chk("midreset_bar", int'(bar_y_t), 204);
    chk("midreset_bx", int'(ball_x_l), 580);
    chk("midreset_by", int'(ball_y_t), 238);
    chk("midreset_play", int'(playing), 0);

    for (int i = 0; i < 6000; i++) begin
      step($urandom_range(0, 399) == 0, $urandom_range(0, 2) == 0,
           1'($urandom), 1'($urandom), $urandom_range(0, 39) == 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
